mem_write_buffer: RTL and testbench

Posted write buffer between the two-level cache's memory port and main memory. It absorbs dirty-line write-backs from L2 so the cache is released one cycle after a write rather than after the full memory latency. It drains buffered lines to memory in the background and forwards buffered data on read hits, so L2 never reads stale lines. The upstream port is pin-compatible with the cache's memory interface; the downstream port is the existing memory interface.

---
 rtl/mem_write_buffer_pkg.sv | 13 +
 rtl/wbuf_cam.sv | 66 ++++++
 rtl/mem_write_buffer.sv | 133 +++++++++++++
 tb/tb_mem_write_buffer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_buffer_pkg.sv
// Shared definitions for the posted write buffer.
//   LINE_W_DEF / ADDR_W_DEF : default line and line-address widths
//   mstate_e                : memory-side FSM encoding (M_IDLE=0, M_WRITE=1, M_READ=2)
package mem_write_buffer_pkg;
  localparam int LINE_W_DEF = 128;
  localparam int ADDR_W_DEF = 28;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_WRITE = 2'd1,
    M_READ  = 2'd2
  } mstate_e;
endpackage

// File: rtl/wbuf_cam.sv
// Entry storage for the write buffer: valid bits, line addresses and line data,
// with a parallel address compare.
//   wr_en/wr_idx/wr_addr/wr_data : write (enqueue or coalesce) one entry
//   inv_en/inv_idx               : invalidate one entry (drain complete)
//   lookup_addr -> hit/hit_idx/hit_data : associative lookup
//   rd_idx -> rd_addr/rd_data    : indexed read (drain source)
module wbuf_cam #(
  parameter  int DEPTH  = 4,
  parameter  int LINE_W = 128,
  parameter  int ADDR_W = 28,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              inv_en,
  input  logic [IDX_W-1:0]  inv_idx,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx,
  output logic [LINE_W-1:0] hit_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LINE_W-1:0] rd_data
);
  logic [DEPTH-1:0]             vld;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][LINE_W-1:0] data_q;
  logic [DEPTH-1:0]             match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign match[i] = vld[i] && (addr_q[i] == lookup_addr);
  end

  // At most one valid entry per address, so the encoder never sees two bits.
  always_comb begin
    hit     = |match;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (match[i]) hit_idx = IDX_W'(i);
  end

  assign hit_data = data_q[hit_idx];
  assign rd_addr  = addr_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Invalidate before write: on a full buffer the enqueue lands in the slot
  // being drained, and the new entry must survive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (inv_en) vld[inv_idx] <= 1'b0;
      if (wr_en) begin
        vld[wr_idx]    <= 1'b1;
        addr_q[wr_idx] <= wr_addr;
        data_q[wr_idx] <= wr_data;
      end
    end
  end
endmodule

// File: rtl/mem_write_buffer.sv
// Posted write buffer between L2's memory port and main memory.
// Upstream (cache):  c_read/c_write/c_addr/c_wdata in, c_rdata/c_ready out.
// Downstream (mem):  mem_read/mem_write/mem_addr/mem_wdata out, mem_rdata/mem_ready in.
// wbuf_empty: no buffered lines and no memory transaction in flight.
// Writes are absorbed into a circular FIFO (coalescing same-address lines),
// drained in the background; reads hit the buffer or go to memory, reads first.
module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [LINE_W-1:0] c_wdata,
  output logic [LINE_W-1:0] c_rdata,
  output logic              c_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wbuf_empty
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  mstate_e            state, state_d;
  logic [IDX_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [LINE_W-1:0]  hit_data, head_data;
  logic [ADDR_W-1:0]  head_addr;
  logic               wr_req, rd_req, drain_done, rd_done, head_hazard;
  logic               coalesce, enq, rd_hit, rd_miss, launch_rd, launch_wr;

  // The request is still asserted during its own c_ready cycle; ignore it.
  assign wr_req      = c_write && !c_ready;
  assign rd_req      = c_read && !c_ready;
  assign drain_done  = (state == M_WRITE) && mem_ready;
  assign rd_done     = (state == M_READ) && mem_ready;
  // Overwriting the line currently on the bus would be lost; wait for it.
  assign head_hazard = hit && (hit_idx == head) && (state == M_WRITE);
  assign coalesce    = wr_req && hit && !head_hazard;
  assign enq         = wr_req && !hit && ((count < CNT_W'(DEPTH)) || drain_done);
  assign rd_hit      = rd_req && hit;
  assign rd_miss     = rd_req && !hit;
  assign wbuf_empty  = (count == '0) && (state == M_IDLE);

  wbuf_cam #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) u_cam (
    .clk        (clk),
    .rst        (proc_reset),
    .wr_en      (coalesce || enq),
    .wr_idx     (coalesce ? hit_idx : tail),
    .wr_addr    (c_addr),
    .wr_data    (c_wdata),
    .inv_en     (drain_done),
    .inv_idx    (head),
    .lookup_addr(c_addr),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .hit_data   (hit_data),
    .rd_idx     (head),
    .rd_addr    (head_addr),
    .rd_data    (head_data)
  );

  always_comb begin
    state_d   = state;
    launch_rd = 1'b0;
    launch_wr = 1'b0;
    unique case (state)
      M_IDLE: begin
        if (rd_miss) begin
          state_d   = M_READ;
          launch_rd = 1'b1;
        end else if (count != '0) begin
          state_d   = M_WRITE;
          launch_wr = 1'b1;
        end
      end
      M_WRITE: if (mem_ready) state_d = M_IDLE;
      M_READ:  if (mem_ready) state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state     <= M_IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      c_ready   <= 1'b0;
      c_rdata   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state   <= state_d;
      c_ready <= coalesce || enq || rd_hit || rd_done;
      if (rd_hit)       c_rdata <= hit_data;
      else if (rd_done) c_rdata <= mem_rdata;

      if (enq)        tail <= tail + 1'b1;
      if (drain_done) head <= head + 1'b1;
      case ({enq, drain_done})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (launch_rd) begin
        mem_read <= 1'b1;
        mem_addr <= c_addr;
      end else if (launch_wr) begin
        mem_write <= 1'b1;
        mem_addr  <= head_addr;
        // A coalesce into the head in the launch cycle must reach memory.
        mem_wdata <= (coalesce && (hit_idx == head)) ? c_wdata : head_data;
      end
      if (drain_done) mem_write <= 1'b0;
      if (rd_done)    mem_read  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: memory responder with programmable latency,
// a flat "latest line per address" view of memory as reference, table vectors
// and hand sequences for stalls, ordering and reset.
module tb_mem_write_buffer;
  localparam int LW = 128;
  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          proc_reset = 1'b1;
  logic          c_read = 1'b0, c_write = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [LW-1:0] c_wdata = '0;
  logic [LW-1:0] c_rdata;
  logic          c_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;
  logic          wbuf_empty;

  always #5 clk = ~clk;

  mem_write_buffer dut (
    .clk(clk), .proc_reset(proc_reset),
    .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ready(c_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wbuf_empty(wbuf_empty)
  );

  typedef struct packed {logic wr; logic [AW-1:0] a; logic [LW-1:0] d;} op_t;
  typedef struct packed {logic rd; logic [AW-1:0] a; logic [LW-1:0] d; logic [3:0] lat;} vec_t;

  op_t           oplog[$];
  logic [LW-1:0] mem_model [logic [AW-1:0]];
  logic [LW-1:0] shadow    [logic [AW-1:0]];
  logic          hold_mem = 1'b0;
  int            mem_lat = 0, lat_cnt = 0, both_hi = 0, rd_cycles = 0;
  int            n_pass = 0, n_chk = 0;
  logic          ew[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [AW-1:0] ea[6] = '{28'h40, 28'h41, 28'hFF0, 28'h42, 28'h43, 28'h44};

  function automatic logic [LW-1:0] dflt(input logic [AW-1:0] a);
    return {4{4'hd, a}};
  endfunction

  task automatic check(input string nm, input logic [LW:0] act, input logic [LW:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Main memory: completes the held request after mem_lat extra cycles.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (mem_read && mem_write) both_hi++;
      if (proc_reset) lat_cnt = 0;
      else if ((mem_read || mem_write) && !hold_mem) begin
        if (lat_cnt >= mem_lat) begin
          lat_cnt   = 0;
          mem_ready = 1'b1;
          if (mem_write) begin
            mem_model[mem_addr] = mem_wdata;
            oplog.push_back({1'b1, mem_addr, mem_wdata});
          end else begin
            mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : dflt(mem_addr);
            oplog.push_back({1'b0, mem_addr, mem_rdata});
          end
        end else lat_cnt++;
      end
    end
  end

  always @(posedge clk) if (mem_read) rd_cycles <= rd_cycles + 1;

  // Cycles from request to c_ready (1 = next cycle), -1 on timeout.
  task automatic req(input logic rd, input logic [AW-1:0] a, input logic [LW-1:0] d,
                     input int max, output int cyc, output logic [LW-1:0] rdat);
    c_addr = a; c_wdata = d; c_read = rd; c_write = !rd; cyc = 0;
    do begin @(negedge clk); cyc++; end while (!c_ready && cyc < max);
    rdat = c_rdata;
    if (!c_ready) cyc = -1;
    c_read = 1'b0; c_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (!wbuf_empty && n < 400) begin @(negedge clk); n++; end
    check(nm, wbuf_empty, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tv[9];
    int            cyc, rc0;
    logic [LW-1:0] r;
    logic [AW-1:0] a;
    logic [LW-1:0] d;
    int            bad;

    tv[0] = '{rd:1'b0, a:28'h100, d:{4{32'hAAAA0100}}, lat:4'd1};
    tv[1] = '{rd:1'b0, a:28'h200, d:{4{32'hBBBB0200}}, lat:4'd1};
    tv[2] = '{rd:1'b0, a:28'h200, d:{4{32'hB2B20200}}, lat:4'd1};
    tv[3] = '{rd:1'b1, a:28'h200, d:{4{32'hB2B20200}}, lat:4'd1};
    tv[4] = '{rd:1'b1, a:28'h100, d:{4{32'hAAAA0100}}, lat:4'd1};
    tv[5] = '{rd:1'b0, a:28'h300, d:{4{32'hCCCC0300}}, lat:4'd1};
    tv[6] = '{rd:1'b0, a:28'h400, d:{4{32'hDDDD0400}}, lat:4'd1};
    tv[7] = '{rd:1'b0, a:28'h300, d:{4{32'hC2C20300}}, lat:4'd1};
    tv[8] = '{rd:1'b1, a:28'h400, d:{4{32'hDDDD0400}}, lat:4'd1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_c_ready", c_ready, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_empty", wbuf_empty, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_c_rdata", c_rdata, 0);
    proc_reset = 1'b0;
    @(negedge clk);

    // Posted write
    mem_lat = 5;
    req(1'b0, 28'h10, {4{32'hA0A00010}}, 20, cyc, r);
    check("posted_lat", cyc, 1);
    check("posted_mem_write", mem_write, 1);
    check("posted_mem_addr", mem_addr, 28'h10);
    wait_empty("posted_empty");
    check("posted_nops", oplog.size(), 1);
    if (oplog.size() > 0) check("posted_op", oplog[0], {1'b1, 28'h10, {4{32'hA0A00010}}});

    // Table vectors with memory stalled on the first line
    oplog.delete();
    hold_mem = 1'b1; mem_lat = 0;
    for (int i = 0; i < 9; i++) begin
      req(tv[i].rd, tv[i].a, tv[i].d, 20, cyc, r);
      check($sformatf("tv%0d_lat", i), cyc, tv[i].lat);
      if (tv[i].rd) check($sformatf("tv%0d_data", i), r, tv[i].d);
    end
    check("tv_head_on_bus", mem_addr, 28'h100);
    hold_mem = 1'b0;
    wait_empty("tv_empty");
    check("tv_nops", oplog.size(), 4);
    for (int i = 0; i < 4 && i < oplog.size(); i++)
      check($sformatf("tv_op%0d", i), oplog[i], {1'b1, tv[(i == 0) ? 0 : (i == 1) ? 2 : (i == 2) ? 7 : 6].a,
                                                 tv[(i == 0) ? 0 : (i == 1) ? 2 : (i == 2) ? 7 : 6].d});

    // Read forwarding: no memory read
    mem_lat = 5;
    rc0 = rd_cycles;
    req(1'b0, 28'h30, {4{32'hC0C00030}}, 20, cyc, r);
    req(1'b1, 28'h30, '0, 20, cyc, r);
    check("fwd_lat", cyc, 1);
    check("fwd_data", r, {4{32'hC0C00030}});
    wait_empty("fwd_empty");
    check("fwd_no_mem_read", rd_cycles - rc0, 0);

    // Full stall, then read priority over remaining drains
    oplog.delete();
    hold_mem = 1'b1; mem_lat = 2;
    for (int i = 0; i < 4; i++) begin
      req(1'b0, AW'(28'h40 + i), {4{32'h40000000 + i}}, 20, cyc, r);
      check($sformatf("fill%0d_lat", i), cyc, 1);
    end
    fork
      req(1'b0, 28'h44, {4{32'h40000004}}, 60, cyc, r);
      begin repeat (6) @(negedge clk); hold_mem = 1'b0; end
    join
    check("full_stalled", cyc > 6, 1);
    req(1'b1, 28'hFF0, '0, 60, cyc, r);
    check("miss_done", cyc > 0, 1);
    check("miss_data", r, dflt(28'hFF0));
    wait_empty("prio_empty");
    check("prio_nops", oplog.size(), 6);
    for (int i = 0; i < 6 && i < oplog.size(); i++)
      check($sformatf("prio_op%0d", i), {oplog[i].wr, oplog[i].a}, {ew[i], ea[i]});

    // Head hazard: write to the line being drained
    oplog.delete();
    hold_mem = 1'b1; mem_lat = 0;
    req(1'b0, 28'h50, {4{32'hD1D10050}}, 20, cyc, r);
    fork
      req(1'b0, 28'h50, {4{32'hD2D20050}}, 60, cyc, r);
      begin repeat (5) @(negedge clk); hold_mem = 1'b0; end
    join
    check("hazard_stalled", cyc > 5, 1);
    wait_empty("hazard_empty");
    check("hazard_nops", oplog.size(), 2);
    if (oplog.size() == 2) begin
      check("hazard_op0", oplog[0], {1'b1, 28'h50, {4{32'hD1D10050}}});
      check("hazard_op1", oplog[1], {1'b1, 28'h50, {4{32'hD2D20050}}});
    end

    // Reset mid-drain
    hold_mem = 1'b1;
    req(1'b0, 28'h60, {4{32'hE0E00060}}, 20, cyc, r);
    check("rmd_mem_write_before", mem_write, 1);
    proc_reset = 1'b1;
    #1;
    check("rmd_mem_write", mem_write, 0);
    check("rmd_empty", wbuf_empty, 1);
    @(negedge clk);
    proc_reset = 1'b0;
    hold_mem = 1'b0;
    oplog.delete();
    @(negedge clk);
    req(1'b1, 28'h60, '0, 40, cyc, r);
    check("rmd_read_data", r, dflt(28'h60));
    check("rmd_read_to_mem", (oplog.size() == 1) && (oplog[0].wr == 1'b0), 1);

    // Randomized traffic against a flat view of memory
    wait_empty("rand_pre_empty");
    shadow = mem_model;
    for (int n = 0; n < 300; n++) begin
      mem_lat = $urandom_range(0, 4);
      a = AW'(28'h700 + $urandom_range(0, 11));
      d = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        req(1'b1, a, '0, 100, cyc, r);
        check($sformatf("rand%0d_done", n), cyc > 0, 1);
        check($sformatf("rand%0d_rdata", n), r, shadow.exists(a) ? shadow[a] : dflt(a));
      end else begin
        shadow[a] = d;
        req(1'b0, a, d, 100, cyc, r);
        check($sformatf("rand%0d_done", n), cyc > 0, 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_empty("rand_empty");
    bad = 0;
    foreach (shadow[k]) if (!mem_model.exists(k) || mem_model[k] !== shadow[k]) bad++;
    check("rand_mem_image", bad, 0);
    check("never_rd_and_wr", both_hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
